corr_readout_sched: RTL and testbench
=====================================

Name: corr_readout_sched

Overview:
- Services a bank of N spread-spectrum correlator blocks that share one register bus.
- Watches each block's CorrelationSeen flag and picks a pending correlator by round-robin.
- Reads that correlator's Cnt, Low, High and Status registers. The Status read clears its CorrelationSeen flag.
- Delivers the result as one report on a valid/ready stream.
- Arbitrates the shared bus between the host port and its own read sequence. Sits between the host bus master and the correlator array.

Parameters:
- N_CORR, 32: number of correlator channels (1..32).
- CORR_BASE, 32'hFE0007A0: address of channel 0's Cnt register.
- CORR_STRIDE, 32'h10: address step between channels. Register offsets are Cnt +0, Low +4, High +8, Status +C.
- HOST_BURST, 4: maximum consecutive host grants in IDLE while any channel is pending.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sched_en  in  1  scheduler enable. When 0, no new sequence starts.
- seen  in  N_CORR  CorrelationSeen level flags, one per correlator
- host_addr  in  32  host bus address
- host_wdata  in  32  host write data
- host_write  in  1  host write strobe
- host_read  in  1  host read strobe
- host_rdata  out  32  host read data
- host_wait  out  1  host access stalled this cycle; host must hold its request
- bus_addr  out  32  shared bus address
- bus_wdata  out  32  shared bus write data
- bus_write  out  1  shared bus write strobe
- bus_read  out  1  shared bus read strobe
- bus_rdata  in  32  shared bus read data, combinational, valid in the same cycle as bus_read
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report
- rpt_id  out  5  channel index of the report
- rpt_cnt  out  32  Cnt register value
- rpt_corr  out  64  signed correlation value {High, Low}
- rpt_status  out  32  Status register value

Behaviour:
- Reset values: every output 0; FSM in IDLE; rr_last = N_CORR-1, so channel 0 wins first; burst counter 0.
- FSM states and transitions: IDLE -> RD_CNT -> RD_LOW -> RD_HIGH -> RD_STAT -> REPORT -> IDLE.
- Each RD_* state lasts exactly one cycle. In that cycle the scheduler drives bus_read=1, bus_write=0 and bus_addr = CORR_BASE + sel*CORR_STRIDE + offset.
- Each RD_* state registers bus_rdata at the clock edge: RD_CNT into rpt_cnt, RD_LOW into rpt_corr[31:0], RD_HIGH into rpt_corr[63:32], RD_STAT into rpt_status.
- REPORT: rpt_valid=1 with all rpt_* fields stable. On rpt_valid && rpt_ready, the next state is IDLE and rpt_valid drops. rpt_* data fields hold their values until overwritten.
- IDLE grant rules:
  - If host_read|host_write and burst counter < HOST_BURST: grant host and stay IDLE. The burst counter increments only when some seen bit is pending.
  - Otherwise, if sched_en && |seen: select sel = first set bit of seen searching from (rr_last+1) mod N_CORR upward with wrap. Set rr_last <= sel, clear the burst counter, go to RD_CNT. A host request in that cycle gets host_wait=1.
  - If the counter has reached HOST_BURST and a channel is pending, the scheduler wins even if the host is requesting.
  - If seen == 0, the burst counter is cleared.
- Host grant (IDLE, or REPORT):
  - bus_addr/bus_wdata/bus_write/bus_read are combinational pass-through of the host signals.
  - host_rdata = bus_rdata when host_read is granted, else 0.
  - host_wait = 0.
- In RD_* states: host_wait = host_read|host_write, host_rdata = 0, and no host strobe reaches the bus.
- REPORT grants the host without burst counting; the scheduler does not use the bus in REPORT.
- Idle bus: when nothing is granted, all bus_* outputs are 0.
- Seen clearing: a correlator drops seen one cycle after its Status read. REPORT always sits between RD_STAT and the next IDLE, so a serviced channel is never reselected on a stale flag.
- If seen for a non-selected channel falls during a sequence, that channel is simply not selected later. No latching of seen.
- sched_en deasserted mid-sequence: the current sequence completes, including REPORT; no new start.
- rst asserted mid-sequence: immediate return to IDLE with all outputs 0; any partial report is discarded.
- N_CORR=1: round-robin degenerates to channel 0 every time.

Test Plan:
- seen=0x1; bus returns Cnt=0x64, Low=0xFFFFFFF0, High=0xFFFFFFFF, Status=0x1 -> four bus reads at FE0007A0/A4/A8/AC on consecutive cycles. Then rpt_valid with rpt_id=0, rpt_cnt=0x64, rpt_corr=-16, rpt_status=1.
- seen=0x5 held, rpt_ready=1 -> reports in order id 0, 2. Then with seen=0x5 again, order is 0 after 2 (wrap). Sequence-1 addresses start FE0007C0 for id 2.
- Host reads continuously in IDLE with seen=0x2, HOST_BURST=4 -> exactly 4 host grants, then host_wait=1 for four RD cycles while addresses FE0007B0..BC are issued. The host then completes its held read in REPORT.
- rpt_ready=0 for 10 cycles in REPORT -> rpt_valid stays 1 and fields stay stable. Host read of FE000104 is granted during REPORT with host_wait=0.
- sched_en=0 with seen=0xFF -> no bus_read from the scheduler. Raise sched_en -> id 0 starts next cycle.
- Assert rst during RD_HIGH -> next cycle all outputs 0 and FSM in IDLE. After release with seen=0x1, a fresh sequence re-reads from Cnt.

Source files
------------

// File: rtl/corr_readout_sched_if.sv
// Host, shared-bus and report-stream signals of the correlator readout scheduler.
// The slave view belongs to the scheduler, the master view to its surroundings.
interface corr_readout_sched_if;
   logic [31:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_write;
   logic        host_read;
   logic [31:0] host_rdata;
   logic        host_wait;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_write;
   logic        bus_read;
   logic [31:0] bus_rdata;
   logic        rpt_valid;
   logic        rpt_ready;
   logic [4:0]  rpt_id;
   logic [31:0] rpt_cnt;
   logic [63:0] rpt_corr;
   logic [31:0] rpt_status;

   modport master (
      output host_addr, host_wdata, host_write, host_read,
      input  host_rdata, host_wait,
      input  bus_addr, bus_wdata, bus_write, bus_read,
      output bus_rdata,
      input  rpt_valid, rpt_id, rpt_cnt, rpt_corr, rpt_status,
      output rpt_ready
   );

   modport slave (
      input  host_addr, host_wdata, host_write, host_read,
      output host_rdata, host_wait,
      output bus_addr, bus_wdata, bus_write, bus_read,
      input  bus_rdata,
      output rpt_valid, rpt_id, rpt_cnt, rpt_corr, rpt_status,
      input  rpt_ready
   );
endinterface

// File: rtl/corr_readout_sched.sv
// Round-robin readout of correlator result registers over a bus
// shared with a host, delivering one report per serviced channel.
module corr_readout_sched #(
   parameter int          N_CORR      = 32,
   parameter logic [31:0] CORR_BASE   = 32'hFE0007A0,
   parameter logic [31:0] CORR_STRIDE = 32'h10,
   parameter int          HOST_BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sched_en,
   input  logic [N_CORR-1:0] seen,
   corr_readout_sched_if.slave io
);

   localparam int BW = $clog2(HOST_BURST + 1);

   typedef enum logic [2:0] {
      IDLE, RD_CNT, RD_LOW, RD_HIGH, RD_STAT, REPORT
   } state_t;

   state_t      state, state_nx;
   logic [4:0]  rr_last, sel, idx;
   logic        found;
   logic [BW-1:0] burst;
   logic        pending, host_req;
   logic        host_go, start, grant;
   logic [31:0] seen_w;
   logic [31:0] rd_off, rd_addr;
   logic [4:0]  id_q;
   logic [31:0] cnt_q, stat_q;
   logic [63:0] corr_q;

   assign seen_w   = 32'(seen);
   assign pending  = |seen;
   assign host_req = io.host_read | io.host_write;

   assign io.rpt_id     = id_q;
   assign io.rpt_cnt    = cnt_q;
   assign io.rpt_corr   = corr_q;
   assign io.rpt_status = stat_q;

   // Pick the first pending channel after the last serviced one, with wrap.
   always_comb begin
      found = 1'b0;
      sel   = rr_last;
      idx   = '0;
      for (int k = 1; k <= N_CORR; k++) begin
         idx = 5'((int'(rr_last) + k) % N_CORR);
         if (!found && seen_w[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Arbitrate IDLE: host wins until its burst allowance runs out.
   always_comb begin
      host_go = 1'b0;
      start   = 1'b0;
      if (state == IDLE) begin
         host_go = host_req &&
                   ((burst < BW'(HOST_BURST)) || !(sched_en && pending));
         start   = !host_go && sched_en && pending;
      end
   end

   // Register address of the current read step.
   always_comb begin
      rd_off = 32'h0;
      unique case (state)
         RD_LOW:  rd_off = 32'h4;
         RD_HIGH: rd_off = 32'h8;
         RD_STAT: rd_off = 32'hC;
         default: rd_off = 32'h0;
      endcase
      rd_addr = CORR_BASE + 32'(rr_last) * CORR_STRIDE + rd_off;
   end

   // Bus mux and host/report handshake outputs.
   always_comb begin
      grant         = 1'b0;
      io.bus_addr   = '0;
      io.bus_wdata  = '0;
      io.bus_write  = 1'b0;
      io.bus_read   = 1'b0;
      io.host_rdata = '0;
      io.host_wait  = 1'b0;
      io.rpt_valid  = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               grant        = host_go;
               io.host_wait = host_req && !host_go;
            end
            RD_CNT, RD_LOW, RD_HIGH, RD_STAT: begin
               io.bus_read  = 1'b1;
               io.bus_addr  = rd_addr;
               io.host_wait = host_req;
            end
            REPORT: begin
               io.rpt_valid = 1'b1;
               grant        = host_req;
            end
            default: ;
         endcase
         if (grant) begin
            io.bus_addr   = io.host_addr;
            io.bus_wdata  = io.host_wdata;
            io.bus_write  = io.host_write;
            io.bus_read   = io.host_read;
            io.host_rdata = io.host_read ? io.bus_rdata : 32'h0;
         end
      end
   end

   // Read sequence progression.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RD_CNT;
         RD_CNT:  state_nx = RD_LOW;
         RD_LOW:  state_nx = RD_HIGH;
         RD_HIGH: state_nx = RD_STAT;
         RD_STAT: state_nx = REPORT;
         REPORT:  if (io.rpt_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Round-robin pointer, host burst counter and captured report fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last <= 5'(N_CORR - 1);
         burst   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         corr_q  <= '0;
         stat_q  <= '0;
      end else begin
         if (state == IDLE) begin
            if (!pending || start)
               burst <= '0;
            else if (host_go && burst < BW'(HOST_BURST))
               burst <= burst + 1'b1;
         end
         if (start) begin
            rr_last <= sel;
            id_q    <= sel;
         end
         unique case (state)
            RD_CNT:  cnt_q          <= io.bus_rdata;
            RD_LOW:  corr_q[31:0]   <= io.bus_rdata;
            RD_HIGH: corr_q[63:32]  <= io.bus_rdata;
            RD_STAT: stat_q         <= io.bus_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_corr_readout_sched.sv
// Directed bench for corr_readout_sched: per-cycle vector table
// plus hand sequences for report stall, enable gating and reset.
module tb_corr_readout_sched;

   localparam logic [31:0] B  = 32'hFE0007A0;
   localparam logic [31:0] HA = 32'hFE000104;
   localparam logic [31:0] HD = 32'hA45A0104;

   logic        clk = 1'b0;
   logic        rst;
   logic        sched_en;
   logic [31:0] seen;
   int          total = 0;
   int          bad   = 0;

   corr_readout_sched_if io ();

   corr_readout_sched dut (
      .clk      (clk),
      .rst      (rst),
      .sched_en (sched_en),
      .seen     (seen),
      .io       (io)
   );

   always #5 clk = ~clk;

   // Correlator register file and other bus slaves.
   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] off;
      logic [4:0]  ch;
      if (a >= B && a < B + 32'd512) begin
         off = a - B;
         ch  = off[8:4];
         case (off[3:2])
            2'd0: return 32'h64 + 32'(ch);
            2'd1: return 32'hFFFFFFF0 - 32'(ch);
            2'd2: return ch[0] ? 32'h0 : 32'hFFFFFFFF;
            default: return 32'h1 + (32'(ch) << 8);
         endcase
      end
      return a ^ 32'h5A5A0000;
   endfunction

   always_comb io.bus_rdata = mem(io.bus_addr);

   typedef struct {
      logic        r;
      logic        en;
      logic [31:0] sn;
      logic        hr;
      logic        rdy;
      logic        erd;
      logic [31:0] ea;
      logic        ew;
      logic        ev;
      logic [4:0]  eid;
      logic [31:0] ehd;
   } vec_t;

   vec_t v[$];

   function automatic vec_t row(
      logic r, logic en, logic [31:0] sn, logic hr, logic rdy,
      logic erd, logic [31:0] ea, logic ew, logic ev,
      logic [4:0] eid, logic [31:0] ehd);
      vec_t t;
      t.r = r; t.en = en; t.sn = sn; t.hr = hr; t.rdy = rdy;
      t.erd = erd; t.ea = ea; t.ew = ew; t.ev = ev;
      t.eid = eid; t.ehd = ehd;
      return t;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sched_en = 1'b0;
      seen = '0;
      io.host_read = 1'b0;
      io.host_addr = '0;
      io.rpt_ready = 1'b0;
      @(negedge clk);
      chk("rst_rd", io.bus_read, 0);
      chk("rst_vld", io.rpt_valid, 0);
      chk("rst_cnt", io.rpt_cnt, 0);
      chk("rst_corr", io.rpt_corr, 0);
      chk("rst_stat", io.rpt_status, 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      sched_en = 1'b0;
      seen = '0;
      io.host_read = 1'b0;
      io.host_write = 1'b0;
      io.host_addr = '0;
      io.host_wdata = 32'h1234_5678;
      io.rpt_ready = 1'b0;

      // r  en sn  hr rdy | rd addr  wait vld id hrdata
      v.push_back(row(1,0,0,0,0, 0,0,0,0,0,0));
      // single channel 0
      v.push_back(row(0,1,1,0,0, 0,0,0,0,0,0));
      v.push_back(row(0,1,1,0,0, 1,B+0,0,0,0,0));
      v.push_back(row(0,1,1,0,0, 1,B+4,0,0,0,0));
      v.push_back(row(0,1,1,0,0, 1,B+8,0,0,0,0));
      v.push_back(row(0,1,1,0,0, 1,B+12,0,0,0,0));
      v.push_back(row(0,1,0,0,0, 0,0,0,1,0,0));
      v.push_back(row(0,1,0,0,1, 0,0,0,1,0,0));
      v.push_back(row(0,1,0,0,1, 0,0,0,0,0,0));
      // channels 0 and 2, then wrap back to 0
      v.push_back(row(1,0,0,0,0, 0,0,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 0,0,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+0,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+4,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+8,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+12,0,0,0,0));
      v.push_back(row(0,1,4,0,1, 0,0,0,1,0,0));
      v.push_back(row(0,1,4,0,1, 0,0,0,0,0,0));
      v.push_back(row(0,1,4,0,1, 1,B+32,0,0,2,0));
      v.push_back(row(0,1,4,0,1, 1,B+36,0,0,2,0));
      v.push_back(row(0,1,4,0,1, 1,B+40,0,0,2,0));
      v.push_back(row(0,1,4,0,1, 1,B+44,0,0,2,0));
      v.push_back(row(0,1,0,0,1, 0,0,0,1,2,0));
      v.push_back(row(0,1,5,0,1, 0,0,0,0,2,0));
      v.push_back(row(0,1,5,0,1, 1,B+0,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+4,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+8,0,0,0,0));
      v.push_back(row(0,1,5,0,1, 1,B+12,0,0,0,0));
      v.push_back(row(0,1,4,0,1, 0,0,0,1,0,0));
      v.push_back(row(0,1,0,0,1, 0,0,0,0,0,0));
      // host burst against pending channel 1
      v.push_back(row(1,0,0,0,0, 0,0,0,0,0,0));
      v.push_back(row(0,1,2,1,1, 1,HA,0,0,0,HD));
      v.push_back(row(0,1,2,1,1, 1,HA,0,0,0,HD));
      v.push_back(row(0,1,2,1,1, 1,HA,0,0,0,HD));
      v.push_back(row(0,1,2,1,1, 1,HA,0,0,0,HD));
      v.push_back(row(0,1,2,1,1, 0,0,1,0,0,0));
      v.push_back(row(0,1,2,1,1, 1,B+16,1,0,1,0));
      v.push_back(row(0,1,2,1,1, 1,B+20,1,0,1,0));
      v.push_back(row(0,1,2,1,1, 1,B+24,1,0,1,0));
      v.push_back(row(0,1,2,1,1, 1,B+28,1,0,1,0));
      v.push_back(row(0,1,0,1,1, 1,HA,0,1,1,HD));
      v.push_back(row(0,1,0,1,1, 1,HA,0,0,1,HD));
      v.push_back(row(0,1,0,0,1, 0,0,0,0,1,0));

      for (int i = 0; i < v.size(); i++) begin
         rst = v[i].r;
         sched_en = v[i].en;
         seen = v[i].sn;
         io.host_read = v[i].hr;
         io.host_addr = v[i].hr ? HA : 32'h0;
         io.rpt_ready = v[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d bus_read", i), io.bus_read, v[i].erd);
         chk($sformatf("v%0d bus_addr", i), io.bus_addr, v[i].ea);
         chk($sformatf("v%0d host_wait", i), io.host_wait, v[i].ew);
         chk($sformatf("v%0d rpt_valid", i), io.rpt_valid, v[i].ev);
         chk($sformatf("v%0d rpt_id", i), io.rpt_id, v[i].eid);
         chk($sformatf("v%0d host_rdata", i), io.host_rdata, v[i].ehd);
         @(posedge clk); #1;
      end
      chk("burst_cnt", io.rpt_cnt, 64'h65);
      chk("burst_corr", io.rpt_corr, 64'h0000_0000_FFFF_FFEF);
      chk("burst_stat", io.rpt_status, 64'h101);

      // report held with rpt_ready low; host served meanwhile
      do_reset();
      seen = 1; sched_en = 1'b1; io.rpt_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 seen = 0;
      @(negedge clk);
      chk("stall_vld", io.rpt_valid, 1);
      chk("stall_id", io.rpt_id, 0);
      chk("stall_cnt", io.rpt_cnt, 64'h64);
      chk("stall_corr", io.rpt_corr, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("stall_stat", io.rpt_status, 64'h1);
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
         io.host_read = (c == 4);
         io.host_addr = (c == 4) ? HA : 32'h0;
         @(negedge clk);
         chk($sformatf("stall%0d vld", c), io.rpt_valid, 1);
         chk($sformatf("stall%0d corr", c), io.rpt_corr,
             64'hFFFF_FFFF_FFFF_FFF0);
         if (c == 4) begin
            chk("rep_host_wait", io.host_wait, 0);
            chk("rep_host_rd", io.bus_read, 1);
            chk("rep_host_addr", io.bus_addr, HA);
            chk("rep_host_rdata", io.host_rdata, HD);
         end
         @(posedge clk); #1;
      end
      io.host_read = 1'b0;
      io.host_addr = '0;
      io.rpt_ready = 1'b1;
      @(negedge clk);
      chk("accept_vld", io.rpt_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_vld", io.rpt_valid, 0);
      chk("after_cnt", io.rpt_cnt, 64'h64);

      // scheduler gated by sched_en
      do_reset();
      seen = 32'hFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("dis%0d rd", c), io.bus_read, 0);
         chk($sformatf("dis%0d vld", c), io.rpt_valid, 0);
         @(posedge clk); #1;
      end
      sched_en = 1'b1;
      @(negedge clk);
      chk("en_idle_rd", io.bus_read, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("en_rd", io.bus_read, 1);
      chk("en_addr", io.bus_addr, B);
      chk("en_id", io.rpt_id, 0);
      sched_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("dis_mid_vld", io.rpt_valid, 1);
      io.rpt_ready = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("dis_post%0d rd", c), io.bus_read, 0);
         chk($sformatf("dis_post%0d vld", c), io.rpt_valid, 0);
         @(posedge clk); #1;
      end

      // reset in the middle of a read sequence
      do_reset();
      seen = 1; sched_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_high_addr", io.bus_addr, B + 8);
      #1;
      rst = 1'b1;
      io.host_read = 1'b1;
      io.host_addr = HA;
      #1;
      chk("mrst_rd", io.bus_read, 0);
      chk("mrst_addr", io.bus_addr, 0);
      chk("mrst_wait", io.host_wait, 0);
      chk("mrst_vld", io.rpt_valid, 0);
      chk("mrst_cnt", io.rpt_cnt, 0);
      chk("mrst_corr", io.rpt_corr, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      io.host_read = 1'b0;
      io.host_addr = '0;
      @(negedge clk);
      chk("rel_idle_rd", io.bus_read, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rel_rd", io.bus_read, 1);
      chk("rel_addr", io.bus_addr, B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
